// File: rtl/bicubic_product_normalizer_pkg.sv
// ============================================================================
//  Package     : bicubic_norm_pkg
//  Description : Shared constants and helpers for the bicubic product
//                normalizer: pixel width and ceiling, lane count, saturation
//                counter width, and a lane saturation popcount.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bicubic_norm_pkg;

  localparam int PIXEL_W   = 8;
  localparam int PIXEL_MAX = 255;
  localparam int LANES     = 4;
  localparam int SAT_CNT_W = 16;

  // Number of lanes flagged as saturated in one output word (0..LANES).
  function automatic logic [2:0] count_sat(input logic [LANES-1:0] i_flags);
    logic [2:0] v_cnt;
    v_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      v_cnt = v_cnt + {2'b00, i_flags[i]};
    end
    return v_cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bicubic_product_normalizer_if.sv
// ============================================================================
//  Interface   : bicubic_product_normalizer_if
//  Description : Upstream product beat (four sign-magnitude lanes, valid/ready)
//                and downstream packed pixel word (valid/ready).
//  Modports    : slave  - normalizer side (consumes products, drives pixels)
//                master - environment side (drives products, consumes pixels)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bicubic_product_normalizer_if #(
  parameter int PRODUCT_WIDTH = 32
);

  logic                     in_valid;
  logic                     in_ready;
  logic [PRODUCT_WIDTH-2:0] inner_product1;
  logic [PRODUCT_WIDTH-2:0] inner_product2;
  logic [PRODUCT_WIDTH-2:0] inner_product3;
  logic [PRODUCT_WIDTH-2:0] inner_product4;
  logic                     inner_product_sign1;
  logic                     inner_product_sign2;
  logic                     inner_product_sign3;
  logic                     inner_product_sign4;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_pixels;

  modport slave (
    input  in_valid,
    output in_ready,
    input  inner_product1, inner_product2, inner_product3, inner_product4,
    input  inner_product_sign1, inner_product_sign2,
    input  inner_product_sign3, inner_product_sign4,
    output out_valid,
    input  out_ready,
    output out_pixels
  );

  modport master (
    output in_valid,
    input  in_ready,
    output inner_product1, inner_product2, inner_product3, inner_product4,
    output inner_product_sign1, inner_product_sign2,
    output inner_product_sign3, inner_product_sign4,
    input  out_valid,
    output out_ready,
    input  out_pixels
  );

endinterface

`default_nettype wire

// File: rtl/bicubic_product_normalizer_lane.sv
// ============================================================================
//  Module      : bicubic_lane_normalize
//  Description : One lane of the normalizer. Stage 1 rounds the magnitude
//                (round-half-up, FRAC_SHIFT fraction bits dropped) and
//                registers the effective sign; stage 2 clamps to 0..255.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_en                - pipeline advance enable
//                i_magnitude, i_sign - lane input (sign 1 = negative)
//                o_pixel             - clamped 8-bit pixel (stage 2)
//                o_saturated         - pixel was clamped (stage 2)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bicubic_lane_normalize
  import bicubic_norm_pkg::*;
#(
  parameter int PRODUCT_WIDTH = 32,
  parameter int FRAC_SHIFT    = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_en,
  input  wire logic [PRODUCT_WIDTH-2:0] i_magnitude,
  input  wire logic                     i_sign,
  output logic      [PIXEL_W-1:0]       o_pixel,
  output logic                          o_saturated
);

  localparam int RW = PRODUCT_WIDTH - FRAC_SHIFT;
  localparam int EW = RW + PIXEL_W;
  localparam logic [PRODUCT_WIDTH-1:0] c_half = PRODUCT_WIDTH'(1) << (FRAC_SHIFT - 1);

  logic [PRODUCT_WIDTH-1:0] w_sum;
  logic [RW-1:0]            w_round;
  logic                     w_neg;
  logic [EW-1:0]            w_ext;
  logic                     w_over;
  logic [PIXEL_W-1:0]       w_pixel;

  logic                     r_neg;
  logic [RW-1:0]            r_round;
  logic [PIXEL_W-1:0]       r_pixel;
  logic                     r_sat;

  // The extra top bit keeps the rounding add from ever overflowing.
  assign w_sum   = {1'b0, i_magnitude} + c_half;
  assign w_round = w_sum[PRODUCT_WIDTH-1:FRAC_SHIFT];
  // Negative zero behaves as zero, so it is neither clamped nor counted.
  assign w_neg   = i_sign && (i_magnitude != '0);

  // Zero-extend so the comparison is legal for any rounded width.
  assign w_ext   = {{PIXEL_W{1'b0}}, r_round};
  assign w_over  = w_ext > EW'(PIXEL_MAX);
  assign w_pixel = r_neg  ? '0 :
                   w_over ? PIXEL_W'(PIXEL_MAX) :
                            w_ext[PIXEL_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg   <= 1'b0;
      r_round <= '0;
      r_pixel <= '0;
      r_sat   <= 1'b0;
    end else if (i_en) begin
      r_neg   <= w_neg;
      r_round <= w_round;
      r_pixel <= w_pixel;
      r_sat   <= r_neg || w_over;
    end
  end

  assign o_pixel     = r_pixel;
  assign o_saturated = r_sat;

endmodule

`default_nettype wire

// File: rtl/bicubic_product_normalizer.sv
// ============================================================================
//  Module      : bicubic_product_normalizer
//  Description : Two-stage normalizer for four sign-magnitude inner products.
//                Rounds off FRAC_SHIFT fraction bits, clamps each lane to an
//                8-bit pixel and packs lane1..lane4 into out_pixels[7:0..31:24].
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                bus       - product input and pixel output handshakes
//                sat_count - saturated-lane counter (BICUBIC_NORM_SAT_CNT_EN)
//  Options     : BICUBIC_NORM_SAT_CNT_EN adds the sticky 16-bit sat_count.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bicubic_product_normalizer
  import bicubic_norm_pkg::*;
#(
  parameter int PRODUCT_WIDTH = 32,
  parameter int FRAC_SHIFT    = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  bicubic_product_normalizer_if.slave   bus
`ifdef BICUBIC_NORM_SAT_CNT_EN
  ,
  output logic      [SAT_CNT_W-1:0]     sat_count
`endif
);

  logic                     w_en;
  logic                     r_s1_valid;
  logic                     r_out_valid;
  logic [PRODUCT_WIDTH-2:0] w_mag   [LANES];
  logic [LANES-1:0]         w_sign;
  logic [PIXEL_W-1:0]       w_pixel [LANES];
  logic [LANES-1:0]         w_sat;
  logic [31:0]              w_packed;

  // Advance whenever the output slot is empty or being drained this cycle.
  assign w_en = !r_out_valid || bus.out_ready;

  assign w_mag[0]  = bus.inner_product1;
  assign w_mag[1]  = bus.inner_product2;
  assign w_mag[2]  = bus.inner_product3;
  assign w_mag[3]  = bus.inner_product4;
  assign w_sign[0] = bus.inner_product_sign1;
  assign w_sign[1] = bus.inner_product_sign2;
  assign w_sign[2] = bus.inner_product_sign3;
  assign w_sign[3] = bus.inner_product_sign4;

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      bicubic_lane_normalize #(
        .PRODUCT_WIDTH (PRODUCT_WIDTH),
        .FRAC_SHIFT    (FRAC_SHIFT)
      ) u_lane (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_en),
        .i_magnitude (w_mag[g]),
        .i_sign      (w_sign[g]),
        .o_pixel     (w_pixel[g]),
        .o_saturated (w_sat[g])
      );
      assign w_packed[g*PIXEL_W +: PIXEL_W] = w_pixel[g];
    end
  endgenerate

  // Bubbles from upstream travel through as cleared valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid  <= bus.in_valid;
      r_out_valid <= r_s1_valid;
    end
  end

  assign bus.in_ready   = w_en;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_pixels = w_packed;

`ifdef BICUBIC_NORM_SAT_CNT_EN
  logic [SAT_CNT_W-1:0] r_sat_count;
  logic [SAT_CNT_W:0]   w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_sat_count} + (SAT_CNT_W+1)'(count_sat(w_sat));

  // Sticky at all-ones: a carry out of the add pins the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (r_out_valid && bus.out_ready) begin
      r_sat_count <= w_cnt_sum[SAT_CNT_W] ? '1 : w_cnt_sum[SAT_CNT_W-1:0];
    end
  end

  assign sat_count = r_sat_count;
`endif

endmodule

`default_nettype wire
